// File: rtl/adc_line_filter.sv
//------------------------------------------------------------------------------
// Module      : adc_line_filter
// Description : Round-robin channel sequencer, block averager and hysteresis
//               line detector for the left/centre/right line sensors.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module adc_line_filter #(
  parameter logic [2:0]  CH_L      = 3'd0,
  parameter logic [2:0]  CH_C      = 3'd1,
  parameter logic [2:0]  CH_R      = 3'd2,
  parameter int          AVG_LOG2  = 2,
  parameter logic [11:0] THRESH_HI = 12'd2000,
  parameter logic [11:0] THRESH_LO = 12'd1800
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sample_valid,
  input  logic [2:0]  sample_chan,
  input  logic [11:0] sample_data,
  output logic [2:0]  ch_sel,
  output logic [11:0] avg_l,
  output logic [11:0] avg_c,
  output logic [11:0] avg_r,
  output logic        avg_valid,
  output logic [2:0]  line,
  output logic [7:0]  mismatch_cnt
);

  localparam int c_acc_w = 12 + AVG_LOG2;
  localparam int c_rnd_w = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam logic [c_rnd_w-1:0] c_rnd_last = c_rnd_w'((1 << AVG_LOG2) - 1);

  typedef enum logic [0:0] {
    ST_ACCUM  = 1'b0,
    ST_UPDATE = 1'b1
  } state_t;

  state_t               r_state;
  logic [1:0]           r_ch_idx;
  logic [2:0]           r_ch_sel;
  logic [c_rnd_w-1:0]   r_round;
  logic [c_acc_w-1:0]   r_acc_l;
  logic [c_acc_w-1:0]   r_acc_c;
  logic [c_acc_w-1:0]   r_acc_r;
  logic [11:0]          r_avg_l;
  logic [11:0]          r_avg_c;
  logic [11:0]          r_avg_r;
  logic                 r_avg_valid;
  logic [2:0]           r_line;
  logic [7:0]           r_mismatch_cnt;

  logic                 w_match;
  logic                 w_mismatch;
  logic [c_acc_w-1:0]   w_acc_sel;
  logic [c_acc_w-1:0]   w_sum;
  logic [11:0]          w_new_l;
  logic [11:0]          w_new_c;
  logic [11:0]          w_new_r;

  function automatic logic [2:0] f_chan(input logic [1:0] idx);
    case (idx)
      2'd0:    return CH_L;
      2'd1:    return CH_C;
      default: return CH_R;
    endcase
  endfunction

  // Hysteresis: only a crossing of the outer thresholds changes the bit.
  function automatic logic f_line(input logic [11:0] avg, input logic cur);
    if (avg >= THRESH_HI)
      return 1'b1;
    else if (avg < THRESH_LO)
      return 1'b0;
    else
      return cur;
  endfunction

  always_comb begin
    w_match    = sample_valid && (sample_chan == r_ch_sel);
    w_mismatch = sample_valid && (sample_chan != r_ch_sel);
    case (r_ch_idx)
      2'd0:    w_acc_sel = r_acc_l;
      2'd1:    w_acc_sel = r_acc_c;
      default: w_acc_sel = r_acc_r;
    endcase
    w_sum   = w_acc_sel + c_acc_w'(sample_data);
    // The closing R sample is folded in on the same edge that publishes.
    w_new_l = r_acc_l[c_acc_w-1 -: 12];
    w_new_c = r_acc_c[c_acc_w-1 -: 12];
    w_new_r = w_sum[c_acc_w-1 -: 12];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state        <= ST_ACCUM;
      r_ch_idx       <= 2'd0;
      r_ch_sel       <= CH_L;
      r_round        <= '0;
      r_acc_l        <= '0;
      r_acc_c        <= '0;
      r_acc_r        <= '0;
      r_avg_l        <= 12'd0;
      r_avg_c        <= 12'd0;
      r_avg_r        <= 12'd0;
      r_avg_valid    <= 1'b0;
      r_line         <= 3'b000;
      r_mismatch_cnt <= 8'd0;
    end else begin
      r_avg_valid <= 1'b0;
      if (w_mismatch && (r_mismatch_cnt != 8'hFF))
        r_mismatch_cnt <= r_mismatch_cnt + 8'd1;

      case (r_state)
        ST_ACCUM: begin
          if (w_match) begin
            if (r_ch_idx == 2'd2) begin
              r_ch_idx <= 2'd0;
              r_ch_sel <= CH_L;
              if (r_round == c_rnd_last) begin
                r_state     <= ST_UPDATE;
                r_round     <= '0;
                r_avg_valid <= 1'b1;
                r_avg_l     <= w_new_l;
                r_avg_c     <= w_new_c;
                r_avg_r     <= w_new_r;
                r_line      <= {f_line(w_new_l, r_line[2]),
                                f_line(w_new_c, r_line[1]),
                                f_line(w_new_r, r_line[0])};
                // Clearing here leaves the UPDATE cycle free to start a window.
                r_acc_l     <= '0;
                r_acc_c     <= '0;
                r_acc_r     <= '0;
              end else begin
                r_round <= r_round + 1'b1;
                r_acc_r <= w_sum;
              end
            end else begin
              if (r_ch_idx == 2'd0)
                r_acc_l <= w_sum;
              else
                r_acc_c <= w_sum;
              r_ch_idx <= r_ch_idx + 2'd1;
              r_ch_sel <= f_chan(r_ch_idx + 2'd1);
            end
          end
        end

        ST_UPDATE: begin
          r_state <= ST_ACCUM;
          if (w_match) begin
            r_acc_l  <= c_acc_w'(sample_data);
            r_ch_idx <= 2'd1;
            r_ch_sel <= CH_C;
          end
        end

        default: r_state <= ST_ACCUM;
      endcase
    end
  end

  assign ch_sel       = r_ch_sel;
  assign avg_l        = r_avg_l;
  assign avg_c        = r_avg_c;
  assign avg_r        = r_avg_r;
  assign avg_valid    = r_avg_valid;
  assign line         = r_line;
  assign mismatch_cnt = r_mismatch_cnt;

endmodule

`default_nettype wire

// File: tb/tb_adc_line_filter.sv
//------------------------------------------------------------------------------
// Module      : tb_adc_line_filter
// Description : Directed bench for adc_line_filter with a window scoreboard.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_adc_line_filter;

  localparam int          N_AVG = 4;
  localparam logic [11:0] T_HI  = 12'd2000;
  localparam logic [11:0] T_LO  = 12'd1800;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        sample_valid = 1'b0;
  logic [2:0]  sample_chan = 3'd0;
  logic [11:0] sample_data = 12'd0;
  logic [2:0]  ch_sel;
  logic [11:0] avg_l, avg_c, avg_r;
  logic        avg_valid;
  logic [2:0]  line;
  logic [7:0]  mismatch_cnt;

  adc_line_filter dut (
    .clk          (clk),
    .rst          (rst),
    .sample_valid (sample_valid),
    .sample_chan  (sample_chan),
    .sample_data  (sample_data),
    .ch_sel       (ch_sel),
    .avg_l        (avg_l),
    .avg_c        (avg_c),
    .avg_r        (avg_r),
    .avg_valid    (avg_valid),
    .line         (line),
    .mismatch_cnt (mismatch_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] l;
    logic [11:0] c;
    logic [11:0] r;
    logic [2:0]  ln;
  } win_t;

  win_t sb[$];
  int   n_cmp = 0;
  int   n_fail = 0;

  // Reference model state
  int          m_idx = 0;
  int          m_round = 0;
  int unsigned m_acc[3] = '{0, 0, 0};
  logic [2:0]  m_line = 3'b000;
  int          m_mis = 0;

  function automatic logic [2:0] exp_chan(input int idx);
    return 3'(idx);
  endfunction

  function automatic logic hyst(input int unsigned avg, input logic cur);
    if (avg >= T_HI) return 1'b1;
    if (avg < T_LO)  return 1'b0;
    return cur;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_idx = 0; m_round = 0; m_acc = '{0, 0, 0}; m_line = 3'b000; m_mis = 0;
  endtask

  task automatic model_accept(input logic [2:0] ch, input logic [11:0] d);
    win_t w;
    if (ch == exp_chan(m_idx)) begin
      m_acc[m_idx] += d;
      if (m_idx == 2) begin
        m_idx = 0;
        m_round++;
        if (m_round == N_AVG) begin
          w.l = 12'(m_acc[0] / N_AVG);
          w.c = 12'(m_acc[1] / N_AVG);
          w.r = 12'(m_acc[2] / N_AVG);
          m_line = {hyst(w.l, m_line[2]), hyst(w.c, m_line[1]), hyst(w.r, m_line[0])};
          w.ln = m_line;
          sb.push_back(w);
          m_acc = '{0, 0, 0};
          m_round = 0;
        end
      end else begin
        m_idx++;
      end
    end else if (m_mis < 255) begin
      m_mis++;
    end
  endtask

  task automatic send(input logic [2:0] ch, input logic [11:0] d);
    @(negedge clk);
    sample_valid = 1'b1; sample_chan = ch; sample_data = d;
    model_accept(ch, d);
  endtask

  task automatic idle();
    @(negedge clk);
    sample_valid = 1'b0;
  endtask

  task automatic send_round(input logic [11:0] l, input logic [11:0] c, input logic [11:0] r);
    send(3'd0, l); send(3'd1, c); send(3'd2, r);
  endtask

  task automatic window(input logic [11:0] l, input logic [11:0] c, input logic [11:0] r);
    for (int i = 0; i < N_AVG; i++) send_round(l, c, r);
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_ch_sel"},    ch_sel, 0);
    chk({tag, "_avg_l"},     avg_l, 0);
    chk({tag, "_avg_c"},     avg_c, 0);
    chk({tag, "_avg_r"},     avg_r, 0);
    chk({tag, "_avg_valid"}, avg_valid, 0);
    chk({tag, "_line"},      line, 0);
    chk({tag, "_mismatch"},  mismatch_cnt, 0);
  endtask

  // Scoreboard monitor: every avg_valid pulse must match a predicted window.
  always @(negedge clk) begin
    if (rst === 1'b1 && avg_valid === 1'b1) begin
      if (sb.size() == 0) begin
        chk("spurious_avg_valid", avg_valid, 0);
      end else begin
        win_t e;
        e = sb.pop_front();
        chk("sb_avg_l", avg_l, e.l);
        chk("sb_avg_c", avg_c, e.c);
        chk("sb_avg_r", avg_r, e.r);
        chk("sb_line",  line,  e.ln);
      end
    end
  end

  initial begin
    // Reset with random strobes on the sample bus
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      sample_valid = 1'($urandom_range(0, 1));
      sample_chan  = 3'($urandom_range(0, 7));
      sample_data  = 12'($urandom);
      chk_zero_outputs("reset");
    end
    @(negedge clk);
    sample_valid = 1'b0;
    rst = 1'b1;
    model_reset();
    idle(); idle();
    chk("post_reset_ch_sel", ch_sel, 0);
    chk("post_reset_mismatch", mismatch_cnt, 0);

    // Basic window
    send_round(12'd1000, 12'd2500, 12'd4095);
    send_round(12'd1002, 12'd2500, 12'd4095);
    send_round(12'd1004, 12'd2500, 12'd4095);
    send_round(12'd1006, 12'd2500, 12'd4095);
    idle();
    chk("basic_avg_valid", avg_valid, 1);
    chk("basic_avg_l", avg_l, 1003);
    chk("basic_avg_c", avg_c, 2500);
    chk("basic_avg_r", avg_r, 4095);
    chk("basic_line", line, 3'b011);
    idle();
    chk("basic_pulse_width", avg_valid, 0);

    // Hysteresis on the centre channel
    window(12'd0, 12'd1900, 12'd0); idle();
    chk("hyst_1900", line[1], 1);
    window(12'd0, 12'd1799, 12'd0); idle();
    chk("hyst_1799", line[1], 0);
    window(12'd0, 12'd1999, 12'd0); idle();
    chk("hyst_1999", line[1], 0);
    window(12'd0, 12'd2000, 12'd0); idle();
    chk("hyst_2000", line[1], 1);
    idle();

    // Sequence errors
    send(3'd1, 12'd500); idle();
    chk("seq_mismatch_1", mismatch_cnt, 1);
    chk("seq_ch_sel_hold", ch_sel, 0);
    for (int i = 0; i < 300; i++) send(3'd1 + 3'($urandom_range(0, 5)), 12'($urandom));
    idle();
    chk("seq_mismatch_sat", mismatch_cnt, 255);
    chk("seq_mismatch_model", mismatch_cnt, m_mis);
    chk("seq_ch_sel_after", ch_sel, exp_chan(m_idx));

    // Reset in the middle of a window
    send_round(12'd777, 12'd777, 12'd777);
    send(3'd0, 12'd777); send(3'd1, 12'd777);
    @(negedge clk);
    sample_valid = 1'b0;
    rst = 1'b0;
    #1;
    chk("midrst_ch_sel", ch_sel, 0);
    chk("midrst_mismatch", mismatch_cnt, 0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    chk("midrst_no_avg_valid", avg_valid, 0);
    window(12'd100, 12'd100, 12'd100); idle();
    chk("midrst_avg_l", avg_l, 100);
    chk("midrst_avg_c", avg_c, 100);
    chk("midrst_avg_r", avg_r, 100);
    idle();

    // Sample arriving in the UPDATE cycle
    window(12'd2200, 12'd2200, 12'd2200);
    send(3'd0, 12'd3000);
    chk("collide_avg_valid", avg_valid, 1);
    idle();
    chk("collide_ch_sel", ch_sel, 1);
    send(3'd1, 12'd1000); send(3'd2, 12'd1000);
    for (int i = 0; i < N_AVG - 1; i++) send_round(12'd3000, 12'd1000, 12'd1000);
    idle();
    chk("collide_next_avg_l", avg_l, 3000);

    // Random back-to-back traffic with occasional out-of-sequence samples
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 7) == 0)
        send(exp_chan((m_idx + 1) % 3), 12'($urandom));
      else
        send(exp_chan(m_idx), 12'($urandom));
    end
    idle(); idle(); idle();
    chk("rand_ch_sel", ch_sel, exp_chan(m_idx));
    chk("rand_mismatch", mismatch_cnt, m_mis);
    chk("pending_windows", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
